act_mem_stream_dma: RTL and testbench
=====================================

# act_mem_stream_dma

Streaming DMA engine that drives the external port of the activation memory (write side `wr_en_ext`/`wr_addr_ext`/`wr_data_ext`, read side `rd_en_ext`/`rd_addr_ext`/`rd_data_ext`).
- **Load command:** moves a burst of words from a valid/ready input stream into the memory.
- **Unload command:** reads a burst back out onto a valid/ready output stream, absorbing the memory's 1-cycle read latency with a small FIFO.

It sits between the host/cluster data mover and the activation memory, and is the only master of the memory's external port.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, external word address width (bit 11 selects bank, handled by the memory).
- `DATA_WIDTH`, 32, word width (4 lanes × 8 bits).
- `LEN_WIDTH`, 13, burst length width (0..4096 words).
- `ADDR_STRIDE`, 4, address increment per word.
- `FIFO_DEPTH`, 4, unload FIFO entries (power of two, ≥4).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted.
- `cmd_dir`  in  1  0 = load, 1 = unload.
- `cmd_addr`  in  ADDR_WIDTH  burst base address.
- `cmd_len`  in  LEN_WIDTH  burst word count.
- `in_valid` / `in_ready`  in/out  1  load stream handshake.
- `in_data`  in  DATA_WIDTH  load word.
- `out_valid` / `out_ready`  out/in  1  unload stream handshake.
- `out_data`  out  DATA_WIDTH  unload word.
- `mem_wr_en`  out  1  drives `wr_en_ext`.
- `mem_wr_addr`  out  ADDR_WIDTH  drives `wr_addr_ext`.
- `mem_wr_data`  out  DATA_WIDTH  drives `wr_data_ext`.
- `mem_rd_en`  out  1  drives `rd_en_ext`.
- `mem_rd_addr`  out  ADDR_WIDTH  drives `rd_addr_ext`.
- `mem_rd_data`  in  DATA_WIDTH  from `rd_data_ext`; valid the cycle after `mem_rd_en`.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle burst-complete pulse.

## Operation
- **States:** IDLE, LOAD, UNLOAD.
- **Command acceptance:**
  - `cmd_ready` = (state == IDLE).
  - On handshake, latch addr, len and dir, and clear the issued counter.
  - Next state is LOAD or UNLOAD.
  - If `cmd_len` == 0, stay in IDLE and pulse `done` next cycle; no memory access occurs.
- **LOAD:**
  - `in_ready` = (state == LOAD), independent of `in_valid`.
  - Each handshake registers `mem_wr_en` = 1, `mem_wr_addr` = base + k·ADDR_STRIDE and `mem_wr_data` = `in_data` (k = 0..len−1).
  - After handshake len−1, return to IDLE.
- **UNLOAD:**
  - At each edge, `mem_rd_en` <= (issued < len) && (fifo_count + `mem_rd_en` + rd_data_valid < FIFO_DEPTH).
  - `mem_rd_addr` = base + k·ADDR_STRIDE.
  - rd_data_valid is `mem_rd_en` delayed one cycle; when it is high, `mem_rd_data` is pushed into the FIFO.
  - `out_valid` = fifo_count ≠ 0; `out_data` = FIFO head; pop on `out_valid` && `out_ready`.
  - Return to IDLE when issued == len, `mem_rd_en` = 0, rd_data_valid = 0 and the FIFO is empty after the pop.
- **Address arithmetic:** modulo 2^ADDR_WIDTH; wrap-around past 0xFFF continues at 0x000 with no error.
- **Mutual exclusion:** `mem_wr_en` and `mem_rd_en` are never high together.
- **Deasserted data:** address/data outputs are 0 whenever the corresponding enable is 0.

## Timing
- **Reset values:** all outputs are 0 during and after reset, except `cmd_ready` = 1. State = IDLE, FIFO empty, counters 0.
- **Reset mid-burst:** aborts immediately; in-flight read data is discarded and no `done` pulse is generated.
- **Cycle numbering:** the command handshake occurs in cycle 0.
- **Load latency:**
  - `in_ready` rises in cycle 1.
  - An input handshake in cycle n produces `mem_wr_en` in cycle n+1.
  - `done` is high in the same cycle as the last `mem_wr_en`; `cmd_ready` is high in that cycle too.
- **Unload latency:**
  - First `mem_rd_en` in cycle 2.
  - `mem_rd_data` valid in cycle 3.
  - First `out_valid` in cycle 4.
  - With `out_ready` held at 1, one word per cycle is sustained.
- **Unload completion:** `done` pulses in the cycle after the final output pop, together with the IDLE return.
- **Backpressure:** with `out_ready` = 0, issue stops once the FIFO plus in-flight reads reach FIFO_DEPTH. The FIFO never overflows.
- **Output hold:** `out_data` is held stable while `out_valid` && !`out_ready`.

## Test plan
- **Load 4 words:** cmd(load, addr 0x010, len 4), words 0xA0..0xA3 with `in_valid` held at 1 → `mem_wr_en` high cycles 2–5, addr 0x010/0x014/0x018/0x01C, `done` in cycle 5.
- **Unload 8 words:** memory model preloaded, `out_ready` = 1 → `out_valid` from cycle 4, 8 consecutive words in address order, `done` one cycle after the last pop.
- **Unload backpressure:** `out_ready` = 0 for 10 cycles mid-burst → at most FIFO_DEPTH words outstanding, no `mem_rd_en` while full, no data lost or duplicated.
- **Wrap and zero length:**
  - Load at 0xFFC, len 3 → addresses 0xFFC, 0x000, 0x004.
  - cmd len 0 → `done` pulse next cycle, no memory access.
- **Reset mid-burst:** `reset` low during unload with 2 reads in flight → all outputs 0, FIFO empty. A new load after release completes correctly.
- **Random traffic:** random `in_valid`/`out_ready` gaps over back-to-back load/unload commands → scoreboard matches, and `mem_wr_en` && `mem_rd_en` is never seen high together.

Source files
------------

// File: rtl/act_mem_stream_dma.sv
// Streaming DMA for the activation memory external port: loads a burst from a
// valid/ready stream into memory, or unloads a burst through a small read FIFO.
module act_mem_stream_dma #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 13,
  parameter int ADDR_STRIDE = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic                  rd_data_valid;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      count_after_pop;
  logic [CNT_W-1:0]      outstanding;

  assign cmd_ready = (state == IDLE);
  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign out_valid = (fifo_count != '0);
  // Masked so stale FIFO contents never appear on the port while empty.
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

  assign push            = rd_data_valid;
  assign pop             = out_valid && out_ready;
  assign count_after_pop = fifo_count - CNT_W'(pop);
  // Words buffered plus reads still in the memory pipeline.
  assign outstanding     = fifo_count + CNT_W'(mem_rd_en) + CNT_W'(rd_data_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      rd_data_valid <= mem_rd_en;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: FIFO storage has no reset; validity is tracked by the reset pointers
  // and count, which keeps the array mappable to plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur_addr    <= '0;
      len_q       <= '0;
      issued      <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      done        <= 1'b0;
    end else begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr <= cmd_addr;
            len_q    <= cmd_len;
            issued   <= '0;
            if (cmd_len == '0) done  <= 1'b1;
            else               state <= cmd_dir ? UNLOAD : LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= cur_addr;
            mem_wr_data <= in_data;
            cur_addr    <= cur_addr + STRIDE;
            issued      <= issued + 1'b1;
            if (issued + 1'b1 == len_q) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        UNLOAD: begin
          if ((issued < len_q) && (outstanding < CNT_W'(FIFO_DEPTH))) begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= cur_addr;
            cur_addr    <= cur_addr + STRIDE;
            issued      <= issued + 1'b1;
          end
          if ((issued == len_q) && !mem_rd_en && !rd_data_valid &&
              (count_after_pop == '0)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_mem_stream_dma.sv
// Directed bench for act_mem_stream_dma with a registered-read memory model and
// a bench-side reference memory for expected burst data.
module tb_act_mem_stream_dma;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [12:0] cmd_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        mem_wr_en;
  logic [11:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [31:0] mem_model [4096];
  logic [31:0] ref_mem   [4096];

  act_mem_stream_dma #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .LEN_WIDTH(13),
    .ADDR_STRIDE(4), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Activation memory external port: write and registered read, 1-cycle latency.
  always @(posedge clk) begin
    if (mem_wr_en) mem_model[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem_model[mem_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("wr_rd_mutex", 64'(mem_wr_en & mem_rd_en), 64'd0);
      if (!mem_wr_en) check("wr_idle_zero", 64'({mem_wr_addr, mem_wr_data}), 64'd0);
      if (!mem_rd_en) check("rd_idle_zero", 64'(mem_rd_addr), 64'd0);
    end
  end

  // mode 0: in_valid held high; otherwise random gaps.
  task automatic run_load(input logic [11:0] base, input int len, input int mode,
                          input logic [31:0] dbase);
    int sent = 0;
    int cyc = 0;
    int first_wr = -1;
    bit prev_hs = 1'b0;
    bit got_done = 1'b0;
    logic [11:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_addr = base; cmd_len = 13'(len);
    in_valid = 1'b0;
    check("load_cmd_ready", 64'(cmd_ready), 64'd1);
    while (!got_done && cyc < 200) begin
      tick();
      cyc++;
      cmd_valid = 1'b0;
      check("load_wr_en", 64'(mem_wr_en), 64'(prev_hs));
      if (prev_hs) begin
        check("load_wr_addr", 64'(mem_wr_addr), 64'(prev_addr));
        check("load_wr_data", 64'(mem_wr_data), 64'(prev_data));
        if (first_wr < 0) first_wr = cyc;
      end
      check("load_in_ready", 64'(in_ready), 64'(sent < len));
      check("load_done", 64'(done), 64'(prev_hs && sent == len));
      if (done) begin
        got_done = 1'b1;
        check("load_done_cmd_ready", 64'(cmd_ready), 64'd1);
        if (mode == 0) begin
          check("load_first_wr_cycle", 64'(first_wr), 64'd2);
          check("load_done_cycle", 64'(cyc), 64'(len + 1));
        end
      end else begin
        in_valid = (sent < len) && (mode == 0 || $urandom_range(0, 2) != 0);
        in_data  = dbase + 32'(sent);
        prev_hs  = in_valid;
        if (prev_hs) begin
          prev_addr = 12'(base + sent * 4);
          prev_data = in_data;
          ref_mem[prev_addr] = prev_data;
          sent++;
        end
      end
    end
    check("load_timeout", 64'(got_done), 64'd1);
    in_valid = 1'b0;
    tick();
    check("load_after_wr_en", 64'(mem_wr_en), 64'd0);
    check("load_after_done", 64'(done), 64'd0);
    check("load_after_busy", 64'(busy), 64'd0);
  endtask

  // mode 0: out_ready held high; 1: out_ready low in cycles 6..15; else random.
  task automatic run_unload(input logic [11:0] base, input int len, input int mode);
    int issued = 0;
    int popped = 0;
    int cyc = 0;
    int first_rd = -1;
    int first_ov = -1;
    int last_pop = -1;
    bit got_done = 1'b0;
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_addr = base; cmd_len = 13'(len);
    out_ready = 1'b0;
    check("unload_cmd_ready", 64'(cmd_ready), 64'd1);
    while (!got_done && cyc < 300) begin
      tick();
      cyc++;
      cmd_valid = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= 6 && cyc < 16);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mem_rd_en) begin
        check("unload_rd_addr", 64'(mem_rd_addr), 64'(12'(base + issued * 4)));
        issued++;
        if (first_rd < 0) first_rd = cyc;
      end
      check("unload_outstanding", 64'((issued - popped) <= FIFO_DEPTH), 64'd1);
      check("unload_overissue", 64'(issued <= len), 64'd1);
      if (out_valid) begin
        if (first_ov < 0) first_ov = cyc;
        check("unload_extra_word", 64'(popped < len), 64'd1);
        check("unload_data", 64'(out_data), 64'(ref_mem[12'(base + popped * 4)]));
        if (out_ready) begin
          popped++;
          last_pop = cyc;
        end
      end
      if (done) begin
        got_done = 1'b1;
        check("unload_done_count", 64'(popped), 64'(len));
        check("unload_done_after_pop", 64'(cyc), 64'(last_pop + 1));
        check("unload_done_out_valid", 64'(out_valid), 64'd0);
        check("unload_done_cmd_ready", 64'(cmd_ready), 64'd1);
        if (mode == 0) check("unload_last_pop_cycle", 64'(last_pop), 64'(len + 3));
      end
    end
    check("unload_timeout", 64'(got_done), 64'd1);
    check("unload_first_rd_cycle", 64'(first_rd), 64'd2);
    check("unload_first_out_cycle", 64'(first_ov), 64'd4);
    out_ready = 1'b0;
    tick();
    check("unload_after_done", 64'(done), 64'd0);
    check("unload_after_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_outputs"}, 64'({busy, done, in_ready, out_valid, mem_wr_en, mem_rd_en}), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_wr_bus"}, 64'({mem_wr_addr, mem_wr_data}), 64'd0);
    check({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
  endtask

  logic [11:0] r_addr;
  int          r_len;

  initial begin
    // Reset state.
    #3;
    check_all_idle("reset_during");
    tick();
    reset = 1'b1;
    tick();
    check_all_idle("reset_after");
    mon_en = 1'b1;

    // Load 4 words at 0x010, in_valid held high.
    run_load(12'h010, 4, 0, 32'h0000_00A0);

    // Preload 0x100..0x12C through the DMA with input gaps.
    run_load(12'h100, 12, 1, 32'hC0DE_0000);

    // Unload 8 words at full rate.
    run_unload(12'h100, 8, 0);

    // Unload 12 words with 10 cycles of backpressure.
    run_unload(12'h100, 12, 1);

    // Address wrap-around past 0xFFF, then read it back.
    run_load(12'hFFC, 3, 0, 32'h5EED_0000);
    check("wrap_ref_0x000", 64'(ref_mem[12'h000]), 64'h5EED_0001);
    run_unload(12'hFFC, 3, 0);

    // Zero-length command.
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_addr = 12'h123; cmd_len = '0;
    check("zero_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy_inready", 64'({busy, in_ready, mem_wr_en, mem_rd_en}), 64'd0);
    tick();
    check("zero_done_pulse", 64'(done), 64'd0);
    check("zero_no_access", 64'({mem_wr_en, mem_rd_en}), 64'd0);

    // Reset mid-unload with two reads in flight.
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_addr = 12'h100; cmd_len = 13'd8;
    out_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("midrst_rd_c2", 64'(mem_rd_en), 64'd1);
    tick();
    check("midrst_rd_c3", 64'(mem_rd_en), 64'd1);
    reset = 1'b0;
    #1;
    check_all_idle("midrst_during");
    tick();
    check_all_idle("midrst_held");
    reset = 1'b1;
    tick();
    check_all_idle("midrst_release");
    run_load(12'h040, 2, 0, 32'h55AA_0000);
    run_unload(12'h040, 2, 0);

    // Random traffic over back-to-back load/unload pairs.
    for (int r = 0; r < 3; r++) begin
      r_addr = 12'($urandom_range(0, 1023) * 4);
      r_len  = $urandom_range(1, 10);
      run_load(r_addr, r_len, 1, $urandom);
      run_unload(r_addr, r_len, 2);
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
